// File: rtl/riscv_rr.sv
// Register-read stage: decodes source/destination fields, reads operands from
// the flattened register file and tracks in-flight writes with a busy scoreboard.
module riscv_rr #(
  parameter int XLEN = 32,
  parameter int REGN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic [XLEN-1:0]      instr_pc,
  input  logic                 instr_valid,
  input  logic                 flush,
  input  logic [XLEN*REGN-1:0] regs_flat,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  output logic                 bubble,
  output logic                 out_valid,
  output logic [XLEN-1:0]      out_pc,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      op1,
  output logic [XLEN-1:0]      op2,
  output logic [4:0]           out_rd,
  output logic [REGN-1:0]      busy
);

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic            uses_rs1, uses_rs2, writes;
  logic            hazard, issue;
  logic [XLEN-1:0] rv1, rv2;
  logic [REGN-1:0] set_vec, clr_vec;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    writes   = 1'b0;
    case (opcode)
      7'b0110011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes = 1'b1; end
      7'b0100011,
      7'b1100011: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      7'b0010011,
      7'b0000011,
      7'b1100111: begin uses_rs1 = 1'b1; writes = 1'b1; end
      7'b0110111,
      7'b0010111,
      7'b1101111: writes = 1'b1;
      default: ;
    endcase
  end

  // busy[0] is never set, so x0 sources can never stall
  assign hazard = instr_valid & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2]));
  assign bubble = hazard & ~flush;
  assign issue  = instr_valid & ~hazard & ~flush;

  assign rv1 = (uses_rs1 && rs1 != 5'd0) ? regs_flat[rs1*XLEN +: XLEN] : '0;
  assign rv2 = (uses_rs2 && rs2 != 5'd0) ? regs_flat[rs2*XLEN +: XLEN] : '0;

  assign set_vec = (issue && writes && rd != 5'd0) ? (REGN'(1) << rd) : '0;
  assign clr_vec = (wb_en && wb_rd != 5'd0) ? (REGN'(1) << wb_rd) : '0;

  // Set applied after clear: a same-edge new writer keeps the register busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= (busy & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      op1       <= '0;
      op2       <= '0;
      out_rd    <= '0;
    end else begin
      out_valid <= issue;
      if (issue) begin
        out_pc    <= instr_pc;
        out_instr <= instr;
        op1       <= rv1;
        op2       <= rv2;
        out_rd    <= writes ? rd : 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_rr.sv
// Directed bench for riscv_rr: issue, RAW stall, same-edge set/clear, x0,
// unused sources, flush and mid-stall reset.
module tb_riscv_rr;
  localparam int XLEN = 32;
  localparam int REGN = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [31:0]          instr;
  logic [XLEN-1:0]      instr_pc;
  logic                 instr_valid;
  logic                 flush;
  logic [XLEN*REGN-1:0] regs_flat;
  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic                 bubble, out_valid;
  logic [XLEN-1:0]      out_pc, op1, op2;
  logic [31:0]          out_instr;
  logic [4:0]           out_rd;
  logic [REGN-1:0]      busy;

  int nchk = 0;
  int nerr = 0;

  riscv_rr #(.XLEN(XLEN), .REGN(REGN)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .flush(flush), .regs_flat(regs_flat),
    .wb_en(wb_en), .wb_rd(wb_rd), .bubble(bubble), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr), .op1(op1), .op2(op2),
    .out_rd(out_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreg(input int i, input logic [31:0] v);
    regs_flat[i*XLEN +: XLEN] = v;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    instr = ins; instr_pc = pc; instr_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b0; instr = '0; instr_pc = '0; instr_valid = 1'b0; flush = 1'b0;
    regs_flat = '0; wb_en = 1'b0; wb_rd = '0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op1", op1, 0);
    chk("rst_bubble", bubble, 0);

    @(negedge clk); rst = 1'b1;
    // ADDI x1,x0,5
    present(32'h0050_0093, 32'h100);
    #1 chk("addi_bubble", bubble, 0);
    step();
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd, 1);
    chk("addi_op1", op1, 0);
    chk("addi_pc", out_pc, 32'h100);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_busy", busy, 32'h2);

    // ADD x2,x1,x1 stalls on x1
    present(32'h0010_8133, 32'h104);
    #1 chk("raw_bubble0", bubble, 1);
    step();
    chk("raw_valid0", out_valid, 0);
    chk("raw_bubble1", bubble, 1);
    step();
    chk("raw_valid1", out_valid, 0);
    wb_en = 1'b1; wb_rd = 5'd1; setreg(1, 32'd5);
    #1 chk("raw_bubble2", bubble, 1);
    step();
    wb_en = 1'b0;
    chk("raw_busy_clr", busy, 32'h0);
    chk("raw_valid2", out_valid, 0);
    chk("raw_bubble3", bubble, 0);
    step();
    chk("raw_valid3", out_valid, 1);
    chk("raw_op1", op1, 5);
    chk("raw_op2", op2, 5);
    chk("raw_rd", out_rd, 2);
    chk("raw_pc", out_pc, 32'h104);
    chk("raw_busy", busy, 32'h4);

    // Same-edge set/clear on x3
    present(32'h0070_0193, 32'h108);
    step();
    chk("se_busy0", busy, 32'hC);
    present(32'h0070_0193, 32'h10C);
    wb_en = 1'b1; wb_rd = 5'd3;
    step();
    wb_en = 1'b0;
    chk("se_busy1", busy, 32'hC);
    chk("se_valid", out_valid, 1);

    // x0 reads as zero; ADD x5,x0,x0
    setreg(0, 32'hDEAD_BEEF);
    present(32'h0000_02B3, 32'h110);
    step();
    chk("x0_op1", op1, 0);
    chk("x0_op2", op2, 0);
    chk("x0_rd", out_rd, 5);
    chk("x0_busy", busy, 32'h2C);
    // ADDI x0,x0,1
    present(32'h0010_0013, 32'h114);
    step();
    chk("x0w_valid", out_valid, 1);
    chk("x0w_rd", out_rd, 0);
    chk("x0w_busy", busy, 32'h2C);

    // LUI x6: rs1/rs2 fields (x8, x3) are ignored though x3 is busy
    setreg(8, 32'h88);
    present(32'h1234_5337, 32'h118);
    #1 chk("lui_bubble", bubble, 0);
    step();
    chk("lui_op1", op1, 0);
    chk("lui_op2", op2, 0);
    chk("lui_rd", out_rd, 6);
    chk("lui_busy", busy, 32'h6C);

    // SW x7,4(x9): reads both sources, no write
    setreg(9, 32'h99); setreg(7, 32'h77);
    present(32'h0074_A223, 32'h11C);
    step();
    chk("sw_op1", op1, 32'h99);
    chk("sw_op2", op2, 32'h77);
    chk("sw_rd", out_rd, 0);
    chk("sw_busy", busy, 32'h6C);

    // ADD x10,x6,x0 with flush while x6 busy
    setreg(6, 32'h66);
    present(32'h0003_0533, 32'h120);
    flush = 1'b1;
    #1 chk("fl_bubble", bubble, 0);
    step();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", busy, 32'h6C);
    chk("fl_hold_rd", out_rd, 0);
    #1 chk("stall_bubble", bubble, 1);

    // Mid-stall asynchronous reset
    #1 rst = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_op1", op1, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_instr", out_instr, 0);
    chk("mr_bubble", bubble, 0);
    @(negedge clk); rst = 1'b1;
    step();
    chk("mr_issue", out_valid, 1);
    chk("mr_rd", out_rd, 10);
    chk("mr_op1v", op1, 32'h66);
    chk("mr_busy2", busy, 32'h400);

    // Idle: valid drops, other outputs hold
    instr_valid = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);
    chk("idle_rd", out_rd, 10);
    chk("idle_pc", out_pc, 32'h120);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/riscv_rr.md
# riscv_rr

Register-read stage of the riscv pipeline. It is the consumer side of the writeback register file. It decodes source and destination register fields from the fetched instruction and reads operands from the flattened register array that writeback drives. A per-register busy scoreboard stalls fetch with `bubble` until every pending write to a source register has retired through writeback. The block sits between fetch and execute and registers one operand bundle per cycle.

## Interface
- XLEN, 32, data width
- REGN, 32, number of architectural registers (index width fixed at 5 bits)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- instr  in  32  instruction word from fetch
- instr_pc  in  XLEN  PC of `instr`
- instr_valid  in  1  `instr` is valid this cycle
- flush  in  1  drop the current input (branch redirect)
- regs_flat  in  XLEN*REGN  register file contents; register i is bits [i*XLEN +: XLEN]
- wb_en  in  1  writeback retires a write this cycle
- wb_rd  in  5  register retired by writeback
- bubble  out  1  combinational stall request to fetch (hold PC)
- out_valid  out  1  operand bundle valid
- out_pc  out  XLEN  registered PC
- out_instr  out  32  registered instruction
- op1  out  XLEN  registered rs1 value
- op2  out  XLEN  registered rs2 value
- out_rd  out  5  registered destination register; 0 if the instruction has no write
- busy  out  REGN  scoreboard; bit i set means a write to register i is in flight

## Operation
- Field decode: opcode = instr[6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- Source use by opcode:
  - 0110011 (OP), 0100011 (STORE), 1100011 (BRANCH): rs1 and rs2.
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR): rs1 only.
  - 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL): no sources.
  - Any other opcode: no sources, no write; the instruction still issues.
- Destination written by OP, OP-IMM, LOAD, JALR, LUI, AUIPC and JAL. STORE and BRANCH do not write.
- hazard = instr_valid & ((uses_rs1 & busy[rs1]) | (uses_rs2 & busy[rs2])). Register 0 is never busy.
- bubble = hazard & ~flush.
- issue = instr_valid & ~hazard & ~flush.
- On issue, at the clock edge:
  - op1/op2 take the values of regs_flat[rs1]/[rs2]. An index of 0 always reads 0, whatever regs_flat holds.
  - Unused sources register 0.
  - out_pc, out_instr and out_rd load; out_valid goes to 1.
  - busy[rd] is set if the instruction writes and rd != 0.
- With no issue, out_valid goes to 0 and the other output registers hold.
- Scoreboard clear: wb_en with wb_rd != 0 clears busy[wb_rd] at the edge.
- Same-edge set and clear of the same register: set wins, because the new writer is younger.
- flush does not touch the scoreboard. In-flight writes still retire.
- Comparisons use registered busy. An operand whose busy bit clears at edge N is read on cycle N, after writeback has updated regs_flat. No bypass path exists.

## Timing
- Reset (rst low, asynchronous):
  - busy = 0, out_valid = 0, out_pc = 0, out_instr = 0, op1 = op2 = 0, out_rd = 0.
  - bubble follows its combinational equation; with busy = 0 it is 0.
- Latency: 1 cycle from an issuing input to out_valid.
- bubble is combinational in the same cycle as the instruction. Fetch holds `instr` stable while bubble = 1.
- Stall length: the cycles until the blocking busy bit clears, plus 0. The instruction issues in the first cycle its sources are not busy.
- Deassertion of rst mid-stall: the first cycle after reset sees an empty scoreboard, so a still-presented instruction issues.
- Throughput: one instruction per cycle when there are no hazards.

## Test plan
- Reset, then instr = ADDI x1,x0,5 (0x00500093) valid → next cycle out_valid = 1, out_rd = 1, op1 = 0, busy = 0x00000002; bubble stays 0.
- Issue ADDI x1, then ADD x2,x1,x1 (0x00108133) with no writeback → bubble = 1 and out_valid = 0 each cycle. Pulse wb_en with wb_rd = 1 and regs_flat[1] = 5 → ADD issues the following cycle with op1 = op2 = 5, busy = 0x00000004.
- Same-edge case: busy[3] set; present ADDI x3 while wb_en with wb_rd = 3 → busy[3] remains 1 after the edge.
- x0 handling: regs_flat[0] = 0xDEADBEEF, issue ADD x5,x0,x0 → op1 = op2 = 0. ADDI x0,x0,1 → busy stays 0 and out_rd = 0.
- Flush: hazard pending with flush = 1 → bubble = 0, out_valid = 0 next cycle, busy unchanged.
- Mid-stall reset: busy[1] = 1 and a stalled ADD is presented; pulse rst low → all outputs 0 immediately. After rst rises, the ADD issues on the next edge.
